// File: rtl/audio_pkg.sv
// Shared types and helpers for the serial audio receive path.
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        PLAY   = 2'd2,
        RESYNC = 2'd3
    } ctrl_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead sample FIFO: the head word is visible on rd_data whenever not empty.
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == LW'(DEPTH));
    assign empty     = (r_level == '0);
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_do_push = push && (!full || w_do_pop);
    assign rd_data   = r_mem[r_rd_ptr];
    assign level     = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_do_push && !w_do_pop)      r_level <= r_level + LW'(1);
            else if (!w_do_push && w_do_pop) r_level <= r_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/audio_rx_controller.sv
// Drives the receiver's active line, buffers received words and releases
// them at the sample rate, with timeout resync and underrun recovery.
module audio_rx_controller
    import audio_pkg::*;
#(
    parameter int CLOCK_HZ       = 25_000_000,
    parameter int SAMPLE_RATE    = 44_100,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2500,
    parameter int RESYNC_CYCLES  = 4
) (
    input  logic                          clk_25mhz,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          rx_data_ready,
    input  logic [SAMPLE_W-1:0]           rx_audio,
    output logic                          rx_active,
    output logic [SAMPLE_W-1:0]           sample_out,
    output logic                          sample_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    state_o,
    output logic [7:0]                    underrun_cnt,
    output logic [7:0]                    overflow_cnt,
    output logic [7:0]                    resync_cnt
);

    localparam int DIV    = CLOCK_HZ / SAMPLE_RATE;
    localparam int PACE_W = $clog2(DIV);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RS_W   = $clog2(RESYNC_CYCLES + 1);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

    ctrl_state_t         r_state;
    ctrl_state_t         w_next;
    logic [PACE_W-1:0]   r_pace;
    logic [TO_W-1:0]     r_timer;
    logic [RS_W-1:0]     r_rs_cnt;
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_valid;
    logic [7:0]          r_underrun;
    logic [7:0]          r_overflow;
    logic [7:0]          r_resync;
    logic                w_rx_active;

    logic                w_run;
    logic                w_push;
    logic                w_tick;
    logic                w_pop;
    logic                w_underrun;
    logic                w_overflow;
    logic                w_timeout;
    logic                w_flush;
    logic                w_full;
    logic                w_empty;
    logic [LVL_W-1:0]    w_level;
    logic [SAMPLE_W-1:0] w_head;

    assign w_run      = enable && (r_state == FILL || r_state == PLAY);
    assign w_push     = w_run && rx_data_ready;
    assign w_tick     = enable && (r_state == PLAY) && (r_pace == PACE_W'(DIV - 1));
    assign w_pop      = w_tick && !w_empty;
    // An empty FIFO never forwards a word pushed in the same cycle.
    assign w_underrun = w_tick && w_empty;
    assign w_overflow = w_push && w_full && !w_pop;
    assign w_timeout  = w_run && (r_timer == TO_W'(TIMEOUT_CYCLES));
    assign w_flush    = (w_next == IDLE);

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk     (clk_25mhz),
        .rst_n   (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (w_flush),
        .wr_data (rx_audio),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (w_level)
    );

    always_comb begin
        w_next      = r_state;
        w_rx_active = 1'b0;
        case (r_state)
            FILL, PLAY: w_rx_active = 1'b1;
            default:    w_rx_active = 1'b0;
        endcase
        if (!enable) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:   w_next = FILL;
                FILL:   if (w_timeout) w_next = RESYNC;
                        else if (w_level >= LVL_W'(FIFO_DEPTH / 2)) w_next = PLAY;
                PLAY:   if (w_timeout) w_next = RESYNC;
                        else if (w_underrun) w_next = FILL;
                RESYNC: if (r_rs_cnt == RS_W'(RESYNC_CYCLES - 1)) w_next = FILL;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Every state entry restarts the word-gap timer, so a freshly started
    // playback gets a full timeout window before the gap is held against it.
    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_pace   <= '0;
            r_timer  <= '0;
            r_rs_cnt <= '0;
        end else begin
            if (r_state != PLAY || w_tick) r_pace <= '0;
            else                           r_pace <= r_pace + PACE_W'(1);

            if (w_next != r_state || w_push)                      r_timer <= '0;
            else if (w_run && r_timer != TO_W'(TIMEOUT_CYCLES))   r_timer <= r_timer + TO_W'(1);

            if (r_state == RESYNC) r_rs_cnt <= r_rs_cnt + RS_W'(1);
            else                   r_rs_cnt <= '0;
        end
    end

    always_ff @(posedge clk_25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_underrun <= '0;
            r_overflow <= '0;
            r_resync   <= '0;
        end else begin
            r_valid <= w_pop;
            if (w_pop)      r_sample   <= w_head;
            if (w_underrun) r_underrun <= sat_inc8(r_underrun);
            if (w_overflow) r_overflow <= sat_inc8(r_overflow);
            if (w_timeout)  r_resync   <= sat_inc8(r_resync);
        end
    end

    assign rx_active    = w_rx_active;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign fifo_level   = w_level;
    assign state_o      = r_state;
    assign underrun_cnt = r_underrun;
    assign overflow_cnt = r_overflow;
    assign resync_cnt   = r_resync;

endmodule
